bcd_updown_counter_mux: RTL
===========================

// Module: bcd_updown_counter_mux
// PURPOSE
//   Parametrised multi-digit BCD up/down counter with built-in tick prescaler and
//   time-multiplexed 7-segment drive. Successor to the single-digit 0-9 demo counter.
//   Adds N digits, enable, synchronous clear/load, wrap-or-saturate mode and carry/borrow
//   output. Sits between the tile I/O (ui_in controls) and uo_out/uio_out display pins.
// PARAMETERS
//   DIGITS    4          number of BCD digits (1..8); digit 0 = least significant
//   PRESCALE  1000000    clk cycles per count tick (>=2)
//   MUX_DIV   1000       clk cycles each digit is shown during scan (>=1)
//   WRAP      1          1: roll over at bounds; 0: saturate at bounds
// PORTS
//   clk        in   1          system clock, all logic on rising edge
//   reset      in   1          synchronous, active-high reset
//   i_en       in   1          count enable; low freezes prescaler and count
//   i_dir      in   1          1 = count up, 0 = count down
//   i_clear    in   1          synchronous clear of count and prescaler
//   i_load     in   1          synchronous load of i_load_val
//   i_load_val in   4*DIGITS   BCD load value, nibble k = digit k
//   o_count    out  4*DIGITS   current BCD count, nibble k = digit k
//   o_tick     out  1          one-cycle pulse, high the cycle o_count shows a ticked value
//   o_carry    out  1          one-cycle pulse with o_tick when count crosses a bound
//   o_seg      out  7          segments {g,f,e,d,c,b,a}, active-high, for selected digit
//   o_dig_sel  out  DIGITS     one-hot active-high digit select, aligned with o_seg
// BEHAVIOUR
//   - Clock is clk; reset is synchronous, active-high, named reset. Priority per edge:
//     reset > i_clear > i_load > tick.
//   - Reset: o_count=0, prescaler=0, o_tick=0, o_carry=0, scan index=0,
//     o_dig_sel=1 (digit 0), o_seg=7'h3F ("0").
//   - Prescaler pre: when i_en=1 counts 0..PRESCALE-1, wraps to 0; tick_int = i_en &&
//     pre==PRESCALE-1 (combinational). i_en=0 holds pre and count.
//   - On edge with tick_int: o_count updated, o_tick<=1; otherwise o_tick<=0. i_dir is
//     sampled on that edge only. First tick after reset: PRESCALE cycles.
//   - Up: ripple BCD increment, digit 9->0 carries into next digit. Count all-9s:
//     WRAP=1 -> all-0s, o_carry<=1; WRAP=0 -> hold, o_carry<=1.
//   - Down: ripple BCD decrement, digit 0->9 borrows. Count all-0s: WRAP=1 -> all-9s,
//     o_carry<=1; WRAP=0 -> hold, o_carry<=1. o_carry=0 on all other edges.
//   - i_clear: o_count<=0, pre<=0, o_tick<=0, o_carry<=0; scan unaffected.
//   - i_load: o_count<=i_load_val with any nibble >9 clamped to 9; pre<=0; no tick/carry.
//   - Clear/load in the same cycle as tick_int win; the tick is dropped.
//   - Digit never holds a value >9 under any input sequence.
//   - Scan: counter counts 0..MUX_DIV-1 free-running (ignores i_en/clear/load); at
//     MUX_DIV-1 scan index advances, DIGITS-1 wraps to 0.
//   - o_seg/o_dig_sel registered from scan index and o_count: one-cycle latency, always
//     change on the same edge. Decode 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
// TESTING  (DIGITS=2, PRESCALE=4, MUX_DIV=2 unless noted)
//   - reset held 2 cycles, i_en=1,i_dir=1 -> o_count=8'h00, o_seg=3F, o_dig_sel=01;
//     o_tick first high 4 cycles after reset release with o_count=8'h01.
//   - load 8'h98, up, 2 ticks -> 8'h99 then 8'h00 with o_carry=1 on that tick only;
//     WRAP=0 variant -> stays 8'h99, o_carry=1 each tick at bound.
//   - count 8'h00, i_dir=0, 1 tick -> 8'h99, o_carry=1; load 8'h10, down -> 8'h09.
//   - load i_load_val=8'hFA -> o_count=8'h99; i_clear asserted on tick cycle -> 8'h00,
//     o_tick=0.
//   - i_en=0 for 10 cycles mid-prescale -> o_count, o_tick static; resumes remaining count.
//   - o_count=8'h37 static -> o_dig_sel alternates 01/10 every 2 cycles, o_seg 07 with 01,
//     4F with 10; reset mid-scan returns o_dig_sel=01 next edge.

Source files
------------

// File: rtl/bcd_updown_counter_mux.sv
// Multi-digit BCD up/down counter with tick prescaler, wrap/saturate bounds,
// and a registered time-multiplexed 7-segment digit scan.
module bcd_updown_counter_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000000,
  parameter int unsigned MUX_DIV  = 1000,
  parameter int unsigned WRAP     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_dir,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_tick,
  output logic                  o_carry,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig_sel
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};

  logic [PW-1:0]       r_pre;
  logic [4*DIGITS-1:0] r_count;
  logic                r_tick;
  logic                r_carry;
  logic [MW-1:0]       r_scan_cnt;
  logic [IW-1:0]       r_scan_idx;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dig_sel;

  logic                w_tick;
  logic                w_all9;
  logic                w_all0;
  logic                w_bound;
  logic                w_c;
  logic                w_b;
  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_load_clamped;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg_dec;
  logic [DIGITS-1:0]   w_sel;

  assign w_tick  = i_en && (r_pre == PW'(PRESCALE - 1));
  assign w_all9  = (r_count == ALL9);
  assign w_all0  = (r_count == '0);
  assign w_bound = i_dir ? w_all9 : w_all0;

  // Ripple BCD increment/decrement; the carry/borrow stops at the first digit that absorbs it.
  always_comb begin
    w_inc = r_count;
    w_dec = r_count;
    w_c   = 1'b1;
    w_b   = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (w_c) begin
        if (r_count[4*k +: 4] >= 4'd9) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
          w_c = 1'b0;
        end
      end
      if (w_b) begin
        if (r_count[4*k +: 4] == 4'd0) begin
          w_dec[4*k +: 4] = 4'd9;
        end else begin
          w_dec[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
          w_b = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next = r_count;
    if (i_dir) begin
      if (w_all9) w_next = (WRAP != 0) ? '0 : r_count;
      else        w_next = w_inc;
    end else begin
      if (w_all0) w_next = (WRAP != 0) ? ALL9 : r_count;
      else        w_next = w_dec;
    end
  end

  always_comb begin
    w_load_clamped = i_load_val;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (i_load_val[4*k +: 4] > 4'd9) w_load_clamped[4*k +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (i_clear || i_load) begin
      r_pre <= '0;
    end else if (i_en) begin
      if (r_pre == PW'(PRESCALE - 1)) r_pre <= '0;
      else                            r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_count <= w_load_clamped;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_tick) begin
      r_count <= w_next;
      r_tick  <= 1'b1;
      r_carry <= w_bound;
    end else begin
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == MW'(MUX_DIV - 1)) begin
      r_scan_cnt <= '0;
      if (r_scan_idx == IW'(DIGITS - 1)) r_scan_idx <= '0;
      else                               r_scan_idx <= r_scan_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nib = 4'd0;
    w_sel = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_scan_idx == IW'(k)) begin
        w_nib    = r_count[4*k +: 4];
        w_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    case (w_nib)
      4'd0:    w_seg_dec = 7'h3F;
      4'd1:    w_seg_dec = 7'h06;
      4'd2:    w_seg_dec = 7'h5B;
      4'd3:    w_seg_dec = 7'h4F;
      4'd4:    w_seg_dec = 7'h66;
      4'd5:    w_seg_dec = 7'h6D;
      4'd6:    w_seg_dec = 7'h7D;
      4'd7:    w_seg_dec = 7'h07;
      4'd8:    w_seg_dec = 7'h7F;
      4'd9:    w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg     <= 7'h3F;
      r_dig_sel <= DIGITS'(1);
    end else begin
      r_seg     <= w_seg_dec;
      r_dig_sel <= w_sel;
    end
  end

  assign o_count   = r_count;
  assign o_tick    = r_tick;
  assign o_carry   = r_carry;
  assign o_seg     = r_seg;
  assign o_dig_sel = r_dig_sel;

endmodule
